// File: rtl/e203_exu_wbck_arb.sv
// Final write-back arbiter: merges the ALU and long-pipe write-back streams
// into the single integer regfile write port through a 1-entry output stage.
// Long-pipe has fixed priority. A starvation counter forces an ALU win after
// STARVE_MAX consecutive cycles in which the ALU was ready to go but lost.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alu_wbck_i_*              ALU write-back request (valid/ready, wdat, rdidx)
//   longp_wbck_i_*            long-pipe write-back request (+ rdwen)
//   rf_stall_i                regfile write port unavailable this cycle
//   rf_wbck_o_*               regfile write port (ena, wdat, rdidx)
//   wbck_pend_valid/rdidx     unwritten entry held in the output stage
module e203_exu_wbck_arb #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int STARVE_MAX  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_wbck_i_valid,
   output logic                   alu_wbck_i_ready,
   input  logic [XLEN-1:0]        alu_wbck_i_wdat,
   input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
   input  logic                   longp_wbck_i_valid,
   output logic                   longp_wbck_i_ready,
   input  logic [XLEN-1:0]        longp_wbck_i_wdat,
   input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,
   input  logic                   longp_wbck_i_rdwen,
   input  logic                   rf_stall_i,
   output logic                   rf_wbck_o_ena,
   output logic [XLEN-1:0]        rf_wbck_o_wdat,
   output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,
   output logic                   wbck_pend_valid,
   output logic [RFIDX_WIDTH-1:0] wbck_pend_rdidx
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

   logic                   r_out_valid;
   logic [XLEN-1:0]        r_out_wdat;
   logic [RFIDX_WIDTH-1:0] r_out_rdidx;
   logic [CW-1:0]          r_starve_cnt;

   logic w_can_load;
   logic w_force_alu;
   logic w_grant_longp;
   logic w_grant_alu;
   logic w_alu_xfer;
   logic w_longp_xfer;
   logic w_alu_wr_need;
   logic w_longp_wr_need;
   logic w_alu_lost;

   // The stage can accept whenever it is empty or its entry retires this cycle.
   assign w_can_load    = ~r_out_valid | ~rf_stall_i;
   assign w_force_alu   = (r_starve_cnt == C_STARVE_MAX);
   assign w_grant_longp = longp_wbck_i_valid & ~(alu_wbck_i_valid & w_force_alu);
   assign w_grant_alu   = alu_wbck_i_valid & ~w_grant_longp;

   assign alu_wbck_i_ready   = w_can_load & w_grant_alu;
   assign longp_wbck_i_ready = w_can_load & w_grant_longp;

   assign w_alu_xfer   = alu_wbck_i_valid & alu_wbck_i_ready;
   assign w_longp_xfer = longp_wbck_i_valid & longp_wbck_i_ready;

   // x0 writes and non-writing long-pipe ops are consumed without a regfile write.
   assign w_alu_wr_need   = (alu_wbck_i_rdidx != '0);
   assign w_longp_wr_need = (longp_wbck_i_rdidx != '0) & longp_wbck_i_rdwen;

   assign w_alu_lost = alu_wbck_i_valid & longp_wbck_i_valid & w_grant_longp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_wdat  <= '0;
         r_out_rdidx <= '0;
      end else if (w_longp_xfer) begin
         r_out_valid <= w_longp_wr_need;
         r_out_wdat  <= longp_wbck_i_wdat;
         r_out_rdidx <= longp_wbck_i_rdidx;
      end else if (w_alu_xfer) begin
         r_out_valid <= w_alu_wr_need;
         r_out_wdat  <= alu_wbck_i_wdat;
         r_out_rdidx <= alu_wbck_i_rdidx;
      end else if (rf_wbck_o_ena) begin
         r_out_valid <= 1'b0;
      end
   end

   // Counts only cycles where the ALU could have loaded but lost; a stalled
   // output stage freezes the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_can_load) begin
         if (w_alu_lost) begin
            if (r_starve_cnt != C_STARVE_MAX)
               r_starve_cnt <= r_starve_cnt + 1'b1;
         end else if (w_alu_xfer | ~alu_wbck_i_valid) begin
            r_starve_cnt <= '0;
         end
      end
   end

   assign rf_wbck_o_ena   = r_out_valid & ~rf_stall_i;
   assign rf_wbck_o_wdat  = r_out_wdat;
   assign rf_wbck_o_rdidx = r_out_rdidx;
   assign wbck_pend_valid = r_out_valid;
   assign wbck_pend_rdidx = r_out_rdidx;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed bench for e203_exu_wbck_arb. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_e203_exu_wbck_arb;

   logic        clk;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [31:0] alu_wdat;
   logic [4:0]  alu_rdidx;
   logic        lp_valid, lp_ready;
   logic [31:0] lp_wdat;
   logic [4:0]  lp_rdidx;
   logic        lp_rdwen;
   logic        rf_stall;
   logic        rf_ena;
   logic [31:0] rf_wdat;
   logic [4:0]  rf_rdidx;
   logic        pend_valid;
   logic [4:0]  pend_rdidx;

   int n_tests = 0;
   int n_fail  = 0;

   e203_exu_wbck_arb #(.XLEN(32), .RFIDX_WIDTH(5), .STARVE_MAX(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .alu_wbck_i_valid   (alu_valid),
      .alu_wbck_i_ready   (alu_ready),
      .alu_wbck_i_wdat    (alu_wdat),
      .alu_wbck_i_rdidx   (alu_rdidx),
      .longp_wbck_i_valid (lp_valid),
      .longp_wbck_i_ready (lp_ready),
      .longp_wbck_i_wdat  (lp_wdat),
      .longp_wbck_i_rdidx (lp_rdidx),
      .longp_wbck_i_rdwen (lp_rdwen),
      .rf_stall_i         (rf_stall),
      .rf_wbck_o_ena      (rf_ena),
      .rf_wbck_o_wdat     (rf_wdat),
      .rf_wbck_o_rdidx    (rf_rdidx),
      .wbck_pend_valid    (pend_valid),
      .wbck_pend_rdidx    (pend_rdidx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      lp_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rf_stall = 1'b0;
      alu_valid = 1'b0; alu_wdat = '0; alu_rdidx = '0;
      lp_valid = 1'b0; lp_wdat = '0; lp_rdidx = '0; lp_rdwen = 1'b0;
      next_cyc();
      rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_ena",   32'(rf_ena), 32'd0);
      chk("rst_wdat",  rf_wdat, 32'd0);
      chk("rst_rdidx", 32'(rf_rdidx), 32'd0);
      chk("rst_pend",  32'(pend_valid), 32'd0);
      chk("rst_cnt",   32'(dut.r_starve_cnt), 32'd0);
      next_cyc();

      // 1: ALU only
      alu_valid = 1'b1; alu_wdat = 32'h1234; alu_rdidx = 5'd5;
      @(negedge clk);
      chk("t1_alu_rdy", 32'(alu_ready), 32'd1);
      chk("t1_ena0",    32'(rf_ena), 32'd0);
      next_cyc();
      idle();
      @(negedge clk);
      chk("t1_ena",   32'(rf_ena), 32'd1);
      chk("t1_wdat",  rf_wdat, 32'h1234);
      chk("t1_rdidx", 32'(rf_rdidx), 32'd5);
      chk("t1_pend",  32'(pend_valid), 32'd1);
      next_cyc();
      @(negedge clk);
      chk("t1_ena_off", 32'(rf_ena), 32'd0);
      next_cyc();

      // 2: both valid continuously; ALU forced in cycle 4
      for (int k = 0; k < 6; k++) begin
         alu_valid = 1'b1; alu_wdat = 32'hB000 + 32'(k); alu_rdidx = 5'd2;
         lp_valid = 1'b1; lp_wdat = 32'hA000 + 32'(k); lp_rdidx = 5'd3; lp_rdwen = 1'b1;
         @(negedge clk);
         chk($sformatf("t2_cnt%0d", k), 32'(dut.r_starve_cnt), (k == 5) ? 32'd0 : 32'(k));
         chk($sformatf("t2_lprdy%0d", k), 32'(lp_ready), (k == 4) ? 32'd0 : 32'd1);
         chk($sformatf("t2_alurdy%0d", k), 32'(alu_ready), (k == 4) ? 32'd1 : 32'd0);
         if (k > 0)
            chk($sformatf("t2_wdat%0d", k), rf_wdat,
                (k == 5) ? 32'hB004 : 32'hA000 + 32'(k - 1));
         next_cyc();
      end
      idle();
      next_cyc();

      // 3: stall with pending entry
      alu_valid = 1'b1; alu_wdat = 32'h55; alu_rdidx = 5'd9;
      next_cyc();
      idle();
      rf_stall = 1'b1;
      lp_valid = 1'b1; lp_wdat = 32'h77; lp_rdidx = 5'd3; lp_rdwen = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t3_ena%0d", k),   32'(rf_ena), 32'd0);
         chk($sformatf("t3_lprdy%0d", k), 32'(lp_ready), 32'd0);
         chk($sformatf("t3_alurdy%0d", k), 32'(alu_ready), 32'd0);
         chk($sformatf("t3_wdat%0d", k),  rf_wdat, 32'h55);
         chk($sformatf("t3_prd%0d", k),   32'(pend_rdidx), 32'd9);
         next_cyc();
      end
      rf_stall = 1'b0;
      @(negedge clk);
      chk("t3_rel_ena",  32'(rf_ena), 32'd1);
      chk("t3_rel_wdat", rf_wdat, 32'h55);
      chk("t3_rel_rd",   32'(rf_rdidx), 32'd9);
      chk("t3_rel_lprdy", 32'(lp_ready), 32'd1);
      next_cyc();
      idle();
      @(negedge clk);
      chk("t3_new_ena",  32'(rf_ena), 32'd1);
      chk("t3_new_wdat", rf_wdat, 32'h77);
      chk("t3_new_rd",   32'(rf_rdidx), 32'd3);
      next_cyc();

      // 4: writes that need no regfile update
      alu_valid = 1'b1; alu_wdat = 32'h99; alu_rdidx = 5'd0;
      @(negedge clk);
      chk("t4_alurdy", 32'(alu_ready), 32'd1);
      next_cyc();
      idle();
      lp_valid = 1'b1; lp_wdat = 32'h88; lp_rdidx = 5'd7; lp_rdwen = 1'b0;
      @(negedge clk);
      chk("t4_lprdy", 32'(lp_ready), 32'd1);
      chk("t4_ena_a", 32'(rf_ena), 32'd0);
      chk("t4_pend_a", 32'(pend_valid), 32'd0);
      next_cyc();
      idle();
      @(negedge clk);
      chk("t4_ena_b",  32'(rf_ena), 32'd0);
      chk("t4_pend_b", 32'(pend_valid), 32'd0);
      next_cyc();

      // 5: back-to-back ALU stream
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            alu_valid = 1'b1; alu_wdat = 32'h100 + 32'(i); alu_rdidx = 5'(i + 1);
         end else begin
            idle();
         end
         @(negedge clk);
         if (i < 8) chk($sformatf("t5_rdy%0d", i), 32'(alu_ready), 32'd1);
         chk($sformatf("t5_ena%0d", i), 32'(rf_ena), (i > 0) ? 32'd1 : 32'd0);
         if (i > 0) begin
            chk($sformatf("t5_wdat%0d", i), rf_wdat, 32'h100 + 32'(i - 1));
            chk($sformatf("t5_rd%0d", i), 32'(rf_rdidx), 32'(i));
         end
         next_cyc();
      end
      @(negedge clk);
      chk("t5_ena_end", 32'(rf_ena), 32'd0);
      next_cyc();

      // 6: reset with pending entry and starve_cnt=3
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_wdat = 32'hC0; alu_rdidx = 5'd4;
         lp_valid = 1'b1; lp_wdat = 32'hD0 + 32'(k); lp_rdidx = 5'd6; lp_rdwen = 1'b1;
         next_cyc();
      end
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_pre_cnt",  32'(dut.r_starve_cnt), 32'd3);
      chk("t6_pre_pend", 32'(pend_valid), 32'd1);
      next_cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ena",  32'(rf_ena), 32'd0);
      chk("t6_pend", 32'(pend_valid), 32'd0);
      chk("t6_cnt",  32'(dut.r_starve_cnt), 32'd0);
      chk("t6_wdat", rf_wdat, 32'd0);
      next_cyc();
      lp_valid = 1'b1; lp_wdat = 32'hE1; lp_rdidx = 5'd8; lp_rdwen = 1'b1;
      @(negedge clk);
      chk("t6_lprdy", 32'(lp_ready), 32'd1);
      next_cyc();
      idle();
      @(negedge clk);
      chk("t6_lp_ena",  32'(rf_ena), 32'd1);
      chk("t6_lp_wdat", rf_wdat, 32'hE1);
      chk("t6_lp_rd",   32'(rf_rdidx), 32'd8);
      next_cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/e203_exu_wbck_arb.md
Name: e203_exu_wbck_arb

Overview:
- Final write-back arbiter, sitting directly downstream of the ALU write-back stage and the long-pipe write-back stage.
- Merges the two valid/ready write-back streams into the single integer regfile write port.
- Long-pipe has fixed priority; a starvation counter guarantees ALU forward progress.
- The regfile write is registered through a 1-entry output stage, giving 1-cycle latency at full throughput.

Parameters:
- XLEN, 32, write-back data width.
- RFIDX_WIDTH, 5, register index width.
- STARVE_MAX, 4, consecutive ALU-loss cycles before ALU is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- alu_wbck_i_valid  in  1  ALU write-back request.
- alu_wbck_i_ready  out  1  ALU write-back accept.
- alu_wbck_i_wdat  in  XLEN  ALU result.
- alu_wbck_i_rdidx  in  RFIDX_WIDTH  ALU destination index.
- longp_wbck_i_valid  in  1  long-pipe write-back request.
- longp_wbck_i_ready  out  1  long-pipe accept.
- longp_wbck_i_wdat  in  XLEN  long-pipe result.
- longp_wbck_i_rdidx  in  RFIDX_WIDTH  long-pipe destination index.
- longp_wbck_i_rdwen  in  1  long-pipe instruction actually writes rd.
- rf_stall_i  in  1  regfile write port unavailable this cycle.
- rf_wbck_o_ena  out  1  regfile write enable.
- rf_wbck_o_wdat  out  XLEN  regfile write data.
- rf_wbck_o_rdidx  out  RFIDX_WIDTH  regfile write index.
- wbck_pend_valid  out  1  output stage holds an unwritten entry (for hazard checks).
- wbck_pend_rdidx  out  RFIDX_WIDTH  index of the pending entry.

Behaviour:
- State:
  - out_valid, out_wdat, out_rdidx: output stage register.
  - starve_cnt: width = clog2(STARVE_MAX+1).
- Reset (rst high at posedge):
  - out_valid=0, out_wdat=0, out_rdidx=0, starve_cnt=0.
  - Any pending entry is discarded, not written.
  - All outputs read 0 the cycle after reset.
- Drain and load:
  - rf_wbck_o_ena = out_valid & ~rf_stall_i. The entry retires on that cycle.
  - can_load = ~out_valid | ~rf_stall_i. Drain and load may occur in the same cycle, giving full throughput.
- Grant (combinational):
  - force_alu = (starve_cnt == STARVE_MAX).
  - grant_longp = longp_valid & ~(alu_valid & force_alu).
  - grant_alu = alu_valid & ~grant_longp.
- Handshakes:
  - alu_wbck_i_ready = can_load & grant_alu.
  - longp_wbck_i_ready = can_load & grant_longp.
  - Ready never depends on the requester's own ready.
  - A transfer occurs on valid & ready.
- Load rule:
  - On a transfer, out_valid' = write_needed, where write_needed = (rdidx != 0) for ALU, and (rdidx != 0) & rdwen for long-pipe. Data and index are captured.
  - A transfer with write_needed=0 is consumed (ready=1) but produces no regfile write.
  - If there is no transfer and the entry drains, out_valid'=0. While stalled the entry holds, stable.
- Starvation counter:
  - If alu_valid & longp_valid & can_load & grant_longp: starve_cnt+1, saturating at STARVE_MAX.
  - Else if an ALU transfer occurs, or alu_valid=0: starve_cnt=0.
  - While can_load=0 the counter holds.
- Pending outputs: wbck_pend_valid = out_valid; wbck_pend_rdidx = out_rdidx.
- Latency: accepted transfer to rf_wbck_o_ena is exactly 1 cycle when rf_stall_i=0.

Test Plan:
1. ALU only, wdat=0x0000_1234, rdidx=5, no stall -> alu ready=1 in the same cycle; next cycle ena=1, wdat=0x1234, rdidx=5; pend_valid=1 during that cycle.
2. Both valid continuously, STARVE_MAX=4 -> longp granted in cycles 0..3; cycle 4 alu granted and longp_ready=0; starve_cnt returns to 0; cycle 5 longp granted again.
3. Entry pending, rf_stall_i=1 for 3 cycles -> ena=0 and both readys=0; output and pend_rdidx stable. Release -> ena=1 with unchanged data, and a new transfer is accepted in the same cycle.
4. ALU rdidx=0, then longp rdidx=7 with rdwen=0 -> both accepted (ready=1); ena stays 0 and pend_valid=0.
5. ALU valid every cycle for 8 cycles with incrementing wdat -> ena high for 8 consecutive cycles, each 1 cycle after its accept, data in order.
6. rst asserted while an entry is pending and starve_cnt=3 -> next cycle ena=0, pend_valid=0, starve_cnt=0. After rst deasserts, a single longp request is accepted immediately.
